// File: rtl/hamming_tx_serializer.sv
// (7,4) Hamming encoder with optional single-bit fault injection, serialising
// each codeword LSB first over a valid/ready stream with a frame-start marker.
module hamming_tx_serializer #(
    parameter int unsigned GAP_CYCLES = 0,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data_in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] inject_pos,
    output logic       ser_out,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       frame_start,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [6:0] shreg, shreg_nxt;
    logic [3:0] gap_cnt, gap_cnt_nxt;
    logic       started;
    logic [6:0] code_enc;
    logic [7:0] inj_mask;
    logic       last_beat;

    // Mask bit k marks codeword bit k-1; inject_pos==0 lands on the discarded bit 0.
    always_comb begin
        inj_mask    = 8'b1 << inject_pos;
        code_enc    = '0;
        code_enc[6] = data_in[3];
        code_enc[5] = data_in[2];
        code_enc[4] = data_in[1];
        code_enc[2] = data_in[0];
        code_enc[0] = data_in[0] ^ data_in[1] ^ data_in[3];
        code_enc[1] = data_in[0] ^ data_in[2] ^ data_in[3];
        code_enc[3] = data_in[1] ^ data_in[2] ^ data_in[3];
        code_enc    = code_enc ^ inj_mask[7:1];
    end

    assign last_beat   = (state == SHIFT) && (cnt == 3'd6) && ser_ready;
    assign in_ready    = ((state == IDLE) && started) || ((GAP_CYCLES == 0) && last_beat);
    assign ser_valid   = (state == SHIFT);
    assign ser_out     = ser_valid ? shreg[0] : IDLE_LEVEL;
    assign frame_start = ser_valid && (cnt == 3'd0);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        gap_cnt_nxt = gap_cnt;
        unique case (state)
            IDLE: begin
                if (in_valid && started) begin
                    shreg_nxt = code_enc;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    if (cnt == 3'd6) begin
                        if (GAP_CYCLES == 0) begin
                            if (in_valid) begin
                                shreg_nxt = code_enc;
                                cnt_nxt   = '0;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            gap_cnt_nxt = 4'(GAP_CYCLES - 1);
                            state_nxt   = GAP;
                        end
                    end else begin
                        cnt_nxt   = cnt + 3'd1;
                        shreg_nxt = shreg >> 1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            gap_cnt <= '0;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            gap_cnt <= gap_cnt_nxt;
            started <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Self-checking bench: directed scenarios plus randomized traffic scored
// against a position-parity Hamming model and an expected-bit queue.
module tb_hamming_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] data0, data1;
    logic [2:0] inj0, inj1;
    logic       iv0, ir0, so0, sv0, sr0, fs0, busy0;
    logic       iv1, ir1, so1, sv1, sr1, fs1, busy1;
    logic       rdy_rand;
    int         n_checks;
    int         n_errors;
    int         cyc;
    logic [1:0] q0[$];

    hamming_tx_serializer #(.GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data0), .in_valid(iv0), .in_ready(ir0),
        .inject_pos(inj0), .ser_out(so0), .ser_valid(sv0), .ser_ready(sr0),
        .frame_start(fs0), .busy(busy0)
    );

    hamming_tx_serializer #(.GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data1), .in_valid(iv1), .in_ready(ir1),
        .inject_pos(inj1), .ser_out(so1), .ser_valid(sv1), .ser_ready(sr1),
        .frame_start(fs1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Codeword bit k sits at Hamming position k+1; parity bit at 2^b covers positions with bit b set.
    function automatic logic [6:0] ref_code(input logic [3:0] d, input logic [2:0] inj);
        logic [7:1] p;
        logic       par;
        p    = '0;
        p[3] = d[0];
        p[5] = d[1];
        p[6] = d[2];
        p[7] = d[3];
        for (int b = 0; b < 3; b++) begin
            par = 1'b0;
            for (int k = 1; k < 8; k++)
                if ((k & (1 << b)) != 0) par ^= p[k];
            p[1 << b] = par;
        end
        if (inj != 3'd0) p[inj] = ~p[inj];
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        logic [6:0] c;
        logic [1:0] e;
        if (!rst_n) begin
            q0.delete();
        end else begin
            check("busy0", busy0, sv0);
            check("in_ready0", ir0, (cyc >= 1) && (!sv0 || (sr0 && q0.size() == 1)));
            if (sv0) begin
                if (sr0) begin
                    check("sb_nonempty", q0.size() != 0, 1);
                    if (q0.size() != 0) begin
                        e = q0.pop_front();
                        check("ser_out", so0, e[0]);
                        check("frame_start", fs0, e[1]);
                    end
                end
            end else begin
                check("idle_out", so0, 1'b1);
                check("idle_fs", fs0, 1'b0);
            end
            if (iv0 && ir0) begin
                c = ref_code(data0, inj0);
                for (int k = 0; k < 7; k++) q0.push_back({k == 0, c[k]});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) sr0 = ($urandom_range(0, 3) != 0);
    end

    task automatic send0(input logic [3:0] d, input logic [2:0] inj);
        int w;
        w     = 0;
        data0 = d;
        inj0  = inj;
        iv0   = 1'b1;
        forever begin
            @(negedge clk);
            if (ir0) break;
            w++;
            if (w > 200) begin
                check("send0_timeout", w, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        iv0   = 1'b0;
        data0 = 4'($urandom);
        inj0  = 3'($urandom);
    endtask

    task automatic send1(input logic [3:0] d);
        int w;
        w     = 0;
        data1 = d;
        inj1  = 3'd0;
        iv1   = 1'b1;
        forever begin
            @(negedge clk);
            if (ir1) break;
            w++;
            if (w > 200) begin
                check("send1_timeout", w, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        iv1 = 1'b0;
    endtask

    task automatic collect(output logic [6:0] bits, output logic [6:0] fsm, output int len,
                           output logic first_sv);
        int n;
        n        = 0;
        len      = 0;
        bits     = '0;
        fsm      = '0;
        first_sv = 1'b0;
        while (n < 7 && len < 100) begin
            @(negedge clk);
            if (len == 0) first_sv = sv0;
            len++;
            if (sv0 && sr0) begin
                bits[n] = so0;
                fsm[n]  = fs0;
                n++;
            end
        end
    endtask

    initial begin
        logic [6:0]  bits, fsm;
        logic        fsv;
        int          len, fsn, both, w;
        logic [13:0] v_sv, v_fs, v_so;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        rdy_rand = 1'b0;
        {data0, inj0, iv0, data1, inj1, iv1} = '0;
        sr0 = 1'b1;
        sr1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", ir0, 0);
        check("rst_ser_valid", sv0, 0);
        check("rst_ser_out", so0, 1);
        check("rst_frame_start", fs0, 0);
        check("rst_busy", busy0, 0);
        check("rst_ser_out1", so1, 0);
        @(posedge clk);
        #1;

        // 1: basic frame, latency, single frame_start
        send0(4'b1011, 3'd0);
        collect(bits, fsm, len, fsv);
        check("t1_bits", bits, 7'b1010101);
        check("t1_fs", fsm, 7'b0000001);
        check("t1_latency", fsv, 1);
        check("t1_len", len, 7);

        // 2: plain and injected codewords
        send0(4'b0001, 3'd0);
        collect(bits, fsm, len, fsv);
        check("t2_bits", bits, 7'b0000111);
        send0(4'b0001, 3'd3);
        collect(bits, fsm, len, fsv);
        check("t2_inj_bits", bits, 7'b0000011);

        // 3: back-to-back with no bubble
        send0(4'b0000, 3'd0);
        fork
            send0(4'b1111, 3'd0);
            begin
                for (int i = 0; i < 14; i++) begin
                    @(negedge clk);
                    v_sv[i] = sv0;
                    v_fs[i] = fs0;
                    v_so[i] = so0;
                end
                @(negedge clk);
                check("t3_end_idle", sv0, 0);
            end
        join
        check("t3_valid_run", v_sv, 14'h3fff);
        check("t3_fs", v_fs, 14'b00000010000001);
        check("t3_bits", v_so, 14'b11111110000000);

        // 4: stall on bit 4
        send0(4'b1011, 3'd0);
        fork
            collect(bits, fsm, len, fsv);
            begin
                repeat (4) @(posedge clk);
                #1 sr0 = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("t4_hold_out", so0, 1);
                    check("t4_hold_fs", fs0, 0);
                    check("t4_hold_valid", sv0, 1);
                end
                @(posedge clk);
                #1 sr0 = 1'b1;
            end
        join
        check("t4_bits", bits, 7'b1010101);
        check("t4_len", len, 10);

        // 5: GAP_CYCLES=2 instance
        send1(4'b0110);
        fsn  = 0;
        both = 0;
        fork
            send1(4'b1001);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (fs1) fsn++;
                    if (fsn >= 2) break;
                    if (!sv1 && !ir1) begin
                        both++;
                        check("t5_gap_busy", busy1, 1);
                    end
                    if (sv1) check("t5_ready_in_shift", ir1, 0);
                    else     check("t5_idle_level", so1, 0);
                end
            end
        join
        check("t5_frames", fsn, 2);
        check("t5_gap_len", both, 2);
        w = 0;
        while (sv1 && w < 20) begin
            @(negedge clk);
            w++;
        end

        // 6: reset during bit 3
        send0(4'($urandom), 3'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", sv0, 0);
        check("t6_fs", fs0, 0);
        check("t6_out", so0, 1);
        check("t6_busy", busy0, 0);
        check("t6_ready", ir0, 0);
        check("t6_valid1", sv1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_after", ir0, 0);
        check("t6_busy_after", busy0, 0);
        @(posedge clk);
        #1;
        send0(4'b1011, 3'd0);
        collect(bits, fsm, len, fsv);
        check("t6_bits", bits, 7'b1010101);
        check("t6_fs", fsm, 7'b0000001);

        // randomized traffic, scored by the monitor
        rdy_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send0(4'($urandom), 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #1 sr0 = 1'b1;
        w = 0;
        while ((sv0 || q0.size() != 0) && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue", q0.size(), 0);
        check("drain_idle", sv0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
